// File: rtl/datapath.sv
// datapath: two signed operand registers, an ALU and an accumulator driven by
// the sequence controller's select/function codes. It returns a sticky
// overflow flag to the controller, and a latched result with a one-cycle valid
// pulse to the downstream consumer. Every output comes straight from a flop.
//
// Handshake: result_valid is a one-cycle pulse with no ready. It is high in the
// cycle after an edge where done=1 and error=0, and result is valid only in
// that cycle. There is no backpressure, so the consumer must take it then.
module datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s2,
   input  logic             s1,
   input  logic             s0,
   input  logic             f2,
   input  logic             f1,
   input  logic             f0,
   input  logic             done,
   input  logic             error,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             ovf,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             err_out
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       sel;
   logic [2:0]       fn;
   logic             is_load;
   logic             is_exec;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] alu_out;
   logic             alu_ov;
   logic [WIDTH-1:0] acc_next;

   assign sel     = {s2, s1, s0};
   assign fn      = {f2, f1, f0};
   assign is_load = (sel == 3'b000);
   assign is_exec = (sel[1:0] == 2'b11);

   // S[2] chains the accumulator back in as the X operand.
   assign x = sel[2] ? acc : ra;
   assign y = rb;

   // ALU: WIDTH-bit wrap-around results, plus a signed-overflow flag per op.
   always_comb begin
      alu_out = '0;
      alu_ov  = 1'b0;
      case (fn)
         3'b000: begin
            alu_out = x + y;
            alu_ov  = (x[WIDTH-1] == y[WIDTH-1]) && (alu_out[WIDTH-1] != x[WIDTH-1]);
         end
         3'b001: alu_out = x & y;
         3'b010: begin
            alu_out = x - y;
            alu_ov  = (x[WIDTH-1] != y[WIDTH-1]) && (alu_out[WIDTH-1] != x[WIDTH-1]);
         end
         3'b011: alu_out = x | y;
         3'b100: alu_out = x ^ y;
         3'b101: alu_out = x;
         3'b110: begin
            alu_out = {x[WIDTH-2:0], 1'b0};
            alu_ov  = x[WIDTH-1] ^ x[WIDTH-2];
         end
         default: begin
            alu_out = -x;
            alu_ov  = (x == MOST_NEG);
         end
      endcase
   end

   // The value ACC takes this edge; completion captures exactly this.
   assign acc_next = is_exec ? alu_out : acc;

   // Operand/accumulator/overflow update from the select code.
   always_ff @(posedge clk) begin
      if (reset) begin
         ra  <= '0;
         rb  <= '0;
         acc <= '0;
         ovf <= 1'b0;
      end else if (is_load) begin
         ra  <= in_a;
         rb  <= in_b;
         ovf <= 1'b0;
      end else if (is_exec) begin
         acc <= alu_out;
         ovf <= ovf | alu_ov;
      end
   end

   // Completion: latch the result and pulse valid, or flag an error completion.
   // A LOAD clears err_out, but an error completion on the same edge still sets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         result       <= '0;
         result_valid <= 1'b0;
         err_out      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (is_load) begin
            err_out <= 1'b0;
         end
         if (done && !error) begin
            result       <= acc_next;
            result_valid <= 1'b1;
         end else if (done && error) begin
            err_out <= 1'b1;
         end
      end
   end

endmodule

// File: doc/datapath.md
# datapath

Arithmetic datapath that sits directly downstream of the sequence controller. It consumes the controller's select code `{s2,s1,s0}`, function code `{f2,f1,f0}`, and the `done`/`error` strobes. It loads two signed operands, runs ALU operations into an accumulator, and returns a registered overflow flag `ovf` that the controller samples to branch to its error state. It also presents a latched result and a one-cycle valid pulse to the consumer downstream.

## Interface
- `WIDTH`, default 8: operand, accumulator and result width, two's-complement signed; minimum 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `s2`, `s1`, `s0`  in  1 each  select code from controller, S = {s2,s1,s0}.
- `f2`, `f1`, `f0`  in  1 each  ALU function code, F = {f2,f1,f0}.
- `done`  in  1  controller completion strobe.
- `error`  in  1  controller error indication.
- `in_a`, `in_b`  in  WIDTH  operand inputs.
- `ovf`  out  1  registered sticky overflow flag, fed back to controller.
- `result`  out  WIDTH  latched final result.
- `result_valid`  out  1  one-cycle pulse, result just updated.
- `err_out`  out  1  sticky error-completion flag.

## Operation
Registers: RA, RB, ACC (WIDTH each), plus `ovf`, `result`, `result_valid` and `err_out`.

Select decode:
- S=000, LOAD: RA<=in_a, RB<=in_b. Clears `ovf` and `err_out`. ACC holds.
- S[1:0]=11, EXEC: ACC<=ALU(X,Y,F), where X = S[2] ? ACC : RA and Y = RB. `ovf` <= `ovf` | ov(op).
- Any other S: hold all of RA, RB, ACC and `ovf`.

ALU, all WIDTH-bit wrap-around, signed:
- F=000, ADD: X+Y. ov when X and Y have the same sign and the result sign differs.
- F=001, AND: X&Y. ov=0.
- F=010, SUB: X−Y. ov when X and Y signs differ and the result sign differs from X.
- F=011, OR: X|Y. ov=0.
- F=100, XOR: X^Y. ov=0.
- F=101, PASS: X. ov=0.
- F=110, SHL: X<<1, zero fill. ov when X[W-1] != X[W-2].
- F=111, NEG: −X. ov when X equals the most-negative value (result wraps to the same value).

Completion, evaluated each edge with `done`=1:
- `error`=0: `result` <= value ACC takes this edge (the ALU output if EXEC, else current ACC). `result_valid`=1 the next cycle, for one cycle only.
- `error`=1: `err_out`<=1. `result` holds and `result_valid` stays 0.
- Same cycle as LOAD with `done`=1, `error`=0: `result` <= current ACC, and the LOAD still occurs.

`ovf` is sticky. It is cleared only by reset or LOAD. If LOAD and EXEC could coincide they cannot, because the S codes are disjoint.

## Timing
- Reset, synchronous and dominant over every other input in the same cycle: RA=RB=ACC=0, `ovf`=0, `result`=0, `result_valid`=0, `err_out`=0.
- LOAD/EXEC latency is 1 cycle. `ovf` reflects an EXEC overflow in the cycle after that EXEC edge, so the controller sees it in its next state.
- `result` and `result_valid` appear 1 cycle after the `done` edge.
- `result_valid` is never high for two consecutive cycles unless `done`=1 on consecutive edges.
- All outputs are direct register outputs with no combinational path from inputs.
- Reset asserted mid-sequence discards the in-flight EXEC and completion.

## Test plan
- **Reset:** drive garbage on all inputs with `reset`=1 for 2 cycles → all outputs 0, and ACC=0 (verify by PASS with S=111, F=101).
- **Nominal sequence** (WIDTH=8): in_a=5, in_b=3. S=000; then S=011, F=000 → ACC=8; then S=111, F=110, `done`=1 → ACC=16.
  - Next cycle: `result`=16, `result_valid`=1 for exactly one cycle, `ovf`=0.
- **Add overflow:** in_a=100, in_b=50, LOAD then ADD → ACC=0x96 (−106) and `ovf`=1 the next cycle.
  - `ovf` stays 1 through 3 cycles of S=010; the next LOAD clears it.
- **Sub and neg edges:** in_a=0x80, in_b=1.
  - SUB → ACC=0x7F, `ovf`=1.
  - After reset and reload: NEG (S=011, F=111) → ACC=0x80, `ovf`=1.
  - in_a=0x40: SHL → 0x80, `ovf`=1.
- **Error completion:** `done`=1 with `error`=1 after an overflow → `err_out`=1, `result` unchanged, `result_valid`=0. A subsequent LOAD clears `err_out`.
- **Reset mid-operation:** `reset`=1 on the same edge as S=011, `done`=1 → ACC=0, `result`=0, `result_valid` stays 0 the next cycle.
